// File: rtl/condiciona_botoes.sv
// Button/confirm input conditioning: 2-FF sync, per-input debounce, single-press validation FSM.
// Define DEBOUNCE_BYPASS_EN to drop the debounce counters (stable level = synchroniser output).
module condiciona_botoes #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       confirma,
    input  logic       habilita,
    output logic [3:0] jogada,
    output logic       tem_jogada,
    output logic       jogada_invalida,
    output logic       confirma_pulso,
    output logic [3:0] db_botoes_estaveis,
    output logic [1:0] db_estado
);

    typedef enum logic [1:0] {
        OCIOSO        = 2'b00,
        DESABILITADO  = 2'b01,
        ESPERA_SOLTAR = 2'b10
    } estado_t;

    // bit 4 is the confirm key, bits 3:0 the play buttons
    logic [4:0] raw;
    logic [4:0] sync1;
    logic [4:0] sync2;
    logic [4:0] stable;

    assign raw = {confirma, botoes};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef DEBOUNCE_BYPASS_EN
    assign stable = sync2;
`else
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar g = 0; g < 5; g++) begin : g_debounce
        logic [CNT_W-1:0] cnt;
        logic             level;

        // level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                cnt   <= '0;
                level <= 1'b0;
            end else if (sync2[g] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign stable[g] = level;
    end
`endif

    logic [3:0] bts;
    logic       um_so;

    assign bts   = stable[3:0];
    assign um_so = (bts != 4'b0000) && ((bts & (bts - 4'd1)) == 4'b0000);

    estado_t    estado;
    estado_t    estado_prox;
    logic [3:0] jogada_prox;
    logic       tem_prox;
    logic       invalida_prox;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado          <= OCIOSO;
            jogada          <= '0;
            tem_jogada      <= 1'b0;
            jogada_invalida <= 1'b0;
        end else begin
            estado          <= estado_prox;
            jogada          <= jogada_prox;
            tem_jogada      <= tem_prox;
            jogada_invalida <= invalida_prox;
        end
    end

    always_comb begin
        estado_prox   = estado;
        jogada_prox   = jogada;
        tem_prox      = 1'b0;
        invalida_prox = 1'b0;
        if (!habilita) begin
            estado_prox = DESABILITADO;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (bts != 4'b0000) begin
                        estado_prox = ESPERA_SOLTAR;
                        if (um_so) begin
                            jogada_prox = bts;
                            tem_prox    = 1'b1;
                        end else begin
                            invalida_prox = 1'b1;
                        end
                    end
                end
                ESPERA_SOLTAR: begin
                    if (bts == 4'b0000) estado_prox = OCIOSO;
                end
                // re-enable never captures a button already held
                DESABILITADO: estado_prox = ESPERA_SOLTAR;
                default:      estado_prox = OCIOSO;
            endcase
        end
    end

    logic conf_prev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            conf_prev      <= 1'b0;
            confirma_pulso <= 1'b0;
        end else begin
            conf_prev      <= stable[4];
            confirma_pulso <= stable[4] & ~conf_prev;
        end
    end

    assign db_botoes_estaveis = bts;
    assign db_estado          = estado;

endmodule
